// File: rtl/pix_pkg.sv
// Shared types and helpers for the frame-buffer writer.
// The check-bit mapping is also used by the bench scoreboard.
package pix_pkg;

    localparam int PIX_W = 12;
    localparam int CHK_W = 8;
    localparam int EXP_W = 6;

    localparam logic ST_IDLE_ENC = 1'b0;
    localparam logic ST_RECV_ENC = 1'b1;

    typedef enum logic {
        ST_IDLE = ST_IDLE_ENC,
        ST_RECV = ST_RECV_ENC
    } state_t;

    function automatic logic [EXP_W-1:0] chk_expected(
        input logic [PIX_W-1:0] pix
    );
        return {pix[11], pix[8], pix[7], pix[4], pix[3], pix[0]};
    endfunction

endpackage

// File: rtl/pix_frame_wr_if.sv
// Pixel input and frame-buffer write bundle.
// slave is the writer's view; master is the producer/observer view.
interface pix_frame_wr_if #(
    parameter int ADDR_W = 15
);
    import pix_pkg::*;

    logic [PIX_W-1:0]  i_pix;
    logic              i_pix_valid;
    logic [CHK_W-1:0]  i_check_code;
    logic              i_check_valid;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [PIX_W-1:0]  o_wr_data;
    logic              o_frame_done;
    logic [7:0]        o_frame_chk;
    logic [7:0]        o_frame_err_cnt;
    logic              o_pix_err;
    logic              o_timeout;
    logic              o_busy;

    modport slave (
        input  i_pix, i_pix_valid, i_check_code, i_check_valid,
        output o_wr_en, o_wr_addr, o_wr_data, o_frame_done,
        output o_frame_chk, o_frame_err_cnt, o_pix_err,
        output o_timeout, o_busy
    );

    modport master (
        output i_pix, i_pix_valid, i_check_code, i_check_valid,
        input  o_wr_en, o_wr_addr, o_wr_data, o_frame_done,
        input  o_frame_chk, o_frame_err_cnt, o_pix_err,
        input  o_timeout, o_busy
    );

endinterface

// File: rtl/pix_chk_cmp.sv
// Check-code compare: combinational mismatch plus a flag
// registered to line up with the frame-buffer write strobe.
module pix_chk_cmp
    import pix_pkg::*;
(
    input  logic             i_clk_sys,
    input  logic             i_rst_n,
    input  logic             i_accept,
    input  logic [PIX_W-1:0] i_pix,
    input  logic [CHK_W-1:0] i_code,
    input  logic             i_code_valid,
    output logic [CHK_W-1:0] o_code,
    output logic             o_mis,
    output logic             o_mis_q
);

    logic mis_d;
    logic mis_q;

    // A missing check code reads as zero and is judged like any other.
    always_comb begin
        o_code = i_code_valid ? i_code : '0;
        o_mis  = o_code[CHK_W-1:2] != chk_expected(i_pix);
        mis_d  = i_accept & o_mis;
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign o_mis_q = mis_q;

endmodule

// File: rtl/pix_frame_wr.sv
// Raster-order frame-buffer writer with per-frame XOR signature,
// saturating error count and inter-pixel timeout.
module pix_frame_wr
    import pix_pkg::*;
#(
    parameter int H_PIX       = 160,
    parameter int V_PIX       = 120,
    parameter int ADDR_W      = 15,
    parameter int TIMEOUT_CYC = 500000,
    parameter int TO_W        = 19
) (
    input  logic           i_clk_sys,
    input  logic           i_rst_n,
    pix_frame_wr_if.slave  bus
);

    localparam int NPIX = H_PIX * V_PIX;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        chk_acc_q, chk_acc_d;
    logic [7:0]        err_acc_q, err_acc_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              done_pend_q, done_pend_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_chk_q, frame_chk_d;
    logic [7:0]        frame_err_q, frame_err_d;
    logic              timeout_q, timeout_d;

    logic              accept;
    logic [CHK_W-1:0]  code_eff;
    logic              mis;
    logic              mis_q;
    logic [ADDR_W-1:0] wr_idx;
    logic [7:0]        base_chk, base_err;
    logic [7:0]        chk_new, err_new;

    assign accept = bus.i_pix_valid;

    pix_chk_cmp u_chk (
        .i_clk_sys    (i_clk_sys),
        .i_rst_n      (i_rst_n),
        .i_accept     (accept),
        .i_pix        (bus.i_pix),
        .i_code       (bus.i_check_code),
        .i_code_valid (bus.i_check_valid),
        .o_code       (code_eff),
        .o_mis        (mis),
        .o_mis_q      (mis_q)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        chk_acc_d    = chk_acc_q;
        err_acc_d    = err_acc_q;
        to_cnt_d     = to_cnt_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        done_pend_d  = 1'b0;
        frame_done_d = done_pend_q;
        frame_chk_d  = frame_chk_q;
        frame_err_d  = frame_err_q;
        timeout_d    = 1'b0;
        wr_idx       = '0;
        base_chk     = '0;
        base_err     = '0;

        if (state_q == ST_RECV) begin
            wr_idx   = addr_q + ADDR_W'(1);
            base_chk = chk_acc_q;
            base_err = err_acc_q;
        end
        chk_new = base_chk ^ code_eff;
        err_new = base_err;
        if (mis && base_err != 8'hFF) begin
            err_new = base_err + 8'd1;
        end

        if (accept) begin
            wr_en_d   = 1'b1;
            addr_d    = wr_idx;
            wr_data_d = bus.i_pix;
            to_cnt_d  = '0;
            // Last pixel: results go out next cycle, FSM is free now.
            if (wr_idx == LAST_ADDR) begin
                done_pend_d = 1'b1;
                frame_chk_d = chk_new;
                frame_err_d = err_new;
                chk_acc_d   = '0;
                err_acc_d   = '0;
                state_d     = ST_IDLE;
            end else begin
                chk_acc_d = chk_new;
                err_acc_d = err_new;
                state_d   = ST_RECV;
            end
        end else begin
            unique case (state_q)
                ST_RECV: begin
                    if (to_cnt_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                        to_cnt_d  = '0;
                        addr_d    = '0;
                        chk_acc_d = '0;
                        err_acc_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                default: begin
                    to_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            chk_acc_q    <= '0;
            err_acc_q    <= '0;
            to_cnt_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_chk_q  <= '0;
            frame_err_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            chk_acc_q    <= chk_acc_d;
            err_acc_q    <= err_acc_d;
            to_cnt_q     <= to_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            done_pend_q  <= done_pend_d;
            frame_done_q <= frame_done_d;
            frame_chk_q  <= frame_chk_d;
            frame_err_q  <= frame_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.o_wr_en         = wr_en_q;
    assign bus.o_wr_addr       = addr_q;
    assign bus.o_wr_data       = wr_data_q;
    assign bus.o_frame_done    = frame_done_q;
    assign bus.o_frame_chk     = frame_chk_q;
    assign bus.o_frame_err_cnt = frame_err_q;
    assign bus.o_pix_err       = mis_q;
    assign bus.o_timeout       = timeout_q;
    assign bus.o_busy          = (state_q == ST_RECV);

endmodule

// File: tb/tb_pix_frame_wr.sv
// Directed bench for pix_frame_wr with a 4x2 frame and a
// 16-cycle timeout; each scenario checks its own results.
module tb_pix_frame_wr;
    import pix_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_to = 0;

    always #5 clk = ~clk;

    pix_frame_wr_if #(.ADDR_W(15)) bus ();

    pix_frame_wr #(
        .H_PIX(4), .V_PIX(2), .ADDR_W(15),
        .TIMEOUT_CYC(16), .TO_W(5)
    ) dut (
        .i_clk_sys (clk),
        .i_rst_n   (rst_n),
        .bus       (bus.slave)
    );

    function automatic logic [7:0] gcode(
        input logic [11:0] p, input logic [1:0] lo
    );
        return {chk_expected(p), lo};
    endfunction

    // Called just after a negedge; returns at the negedge after the sampling edge.
    task automatic send(
        input logic [11:0] p, input logic [7:0] c, input logic cv
    );
        bus.i_pix = p;
        bus.i_check_code = c;
        bus.i_check_valid = cv;
        bus.i_pix_valid = 1'b1;
        @(negedge clk);
        bus.i_pix_valid = 1'b0;
        bus.i_check_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            if (bus.o_frame_done) n_done++;
            if (bus.o_timeout) n_to++;
        end
    endtask

    task automatic test_reset;
        bus.i_pix = '0;
        bus.i_pix_valid = 1'b0;
        bus.i_check_code = '0;
        bus.i_check_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_frame_done,
             bus.o_frame_chk, bus.o_frame_err_cnt, bus.o_pix_err,
             bus.o_timeout, bus.o_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got addr=%0d wr=%b busy=%b exp all zero",
                     bus.o_wr_addr, bus.o_wr_en, bus.o_busy);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_frame;
        n_done = 0;
        n_to = 0;
        for (int i = 0; i < 8; i++) begin
            send(12'(i), gcode(12'(i), (i == 2) ? 2'b11 : 2'b00), 1'b1);
            checks++;
            if (!bus.o_wr_en || bus.o_wr_addr !== 15'(i) ||
                bus.o_wr_data !== 12'(i) || bus.o_pix_err) begin
                errors++;
                $display("FAIL t1_write%0d: got en=%b addr=%0d data=%h err=%b exp 1 %0d %h 0",
                         i, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_pix_err, i, i);
            end
            checks++;
            if (bus.o_frame_done !== 1'b0) begin
                errors++;
                $display("FAIL t1_early_done%0d: got 1 exp 0", i);
            end
            if (i < 7) idle(11);
        end
        @(negedge clk);
        checks++;
        if (bus.o_frame_done !== 1'b1 || bus.o_frame_chk !== 8'h03 ||
            bus.o_frame_err_cnt !== 8'd0 || bus.o_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL t1_done: got done=%b chk=%h err=%0d wr=%b exp 1 03 0 0",
                     bus.o_frame_done, bus.o_frame_chk, bus.o_frame_err_cnt, bus.o_wr_en);
        end
        idle(3);
        checks++;
        if (n_done !== 0 || n_to !== 0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_tail: got extra_done=%0d to=%0d busy=%b exp 0 0 0",
                     n_done, n_to, bus.o_busy);
        end
    endtask

    task automatic test_mismatch;
        logic [11:0] p;
        for (int i = 0; i < 8; i++) begin
            p = (i == 3) ? 12'hA5C : 12'(i);
            send(p, (i == 3) ? 8'h00 : gcode(p, 2'b00), 1'b1);
            checks++;
            if (!bus.o_wr_en || bus.o_wr_addr !== 15'(i) || bus.o_wr_data !== p ||
                bus.o_pix_err !== (i == 3)) begin
                errors++;
                $display("FAIL t2_write%0d: got en=%b addr=%0d data=%h perr=%b exp 1 %0d %h %b",
                         i, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_pix_err,
                         i, p, (i == 3));
            end
            if (i < 7) idle(2);
        end
        @(negedge clk);
        checks++;
        if (bus.o_frame_done !== 1'b1 || bus.o_frame_chk !== 8'h04 ||
            bus.o_frame_err_cnt !== 8'd1 || bus.o_pix_err !== 1'b0) begin
            errors++;
            $display("FAIL t2_done: got done=%b chk=%h err=%0d perr=%b exp 1 04 1 0",
                     bus.o_frame_done, bus.o_frame_chk, bus.o_frame_err_cnt, bus.o_pix_err);
        end
        idle(3);
    endtask

    task automatic test_timeout;
        int first_k;
        int pulses;
        int dones;
        first_k = 0;
        pulses = 0;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            send(12'h020 + 12'(i), gcode(12'h020 + 12'(i), 2'b00), 1'b1);
            if (i < 2) idle(3);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.o_timeout) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
            if (bus.o_frame_done) dones++;
        end
        checks++;
        if (first_k !== 16 || pulses !== 1) begin
            errors++;
            $display("FAIL t3_timeout_at: got cycle=%0d pulses=%0d exp 16 1",
                     first_k, pulses);
        end
        checks++;
        if (dones !== 0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL t3_no_done: got done=%0d busy=%b exp 0 0", dones, bus.o_busy);
        end
        send(12'h0F0, gcode(12'h0F0, 2'b00), 1'b1);
        checks++;
        if (!bus.o_wr_en || bus.o_wr_addr !== 15'd0 || bus.o_wr_data !== 12'h0F0) begin
            errors++;
            $display("FAIL t3_restart: got en=%b addr=%0d data=%h exp 1 0 0f0",
                     bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
        end
        idle(20);
    endtask

    task automatic test_timeout_race;
        logic [11:0] p;
        n_to = 0;
        n_done = 0;
        send(12'h100, gcode(12'h100, 2'b00), 1'b1);
        idle(15);
        send(12'h101, gcode(12'h101, 2'b00), 1'b1);
        checks++;
        if (!bus.o_wr_en || bus.o_wr_addr !== 15'd1 || bus.o_timeout || n_to !== 0) begin
            errors++;
            $display("FAIL t4_race: got en=%b addr=%0d to=%b early_to=%0d exp 1 1 0 0",
                     bus.o_wr_en, bus.o_wr_addr, bus.o_timeout, n_to);
        end
        idle(1);
        checks++;
        if (n_to !== 0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL t4_alive: got to=%0d busy=%b exp 0 1", n_to, bus.o_busy);
        end
        for (int i = 2; i < 8; i++) begin
            p = 12'h100 + 12'(i);
            send(p, gcode(p, 2'b00), (i != 4));
            checks++;
            if (bus.o_wr_addr !== 15'(i) || bus.o_pix_err !== (i == 4)) begin
                errors++;
                $display("FAIL t4_write%0d: got addr=%0d perr=%b exp %0d %b",
                         i, bus.o_wr_addr, bus.o_pix_err, i, (i == 4));
            end
            if (i < 7) idle(1);
        end
        @(negedge clk);
        checks++;
        if (bus.o_frame_done !== 1'b1 || bus.o_frame_chk !== 8'h40 ||
            bus.o_frame_err_cnt !== 8'd1 || n_to !== 0) begin
            errors++;
            $display("FAIL t4_done: got done=%b chk=%h err=%0d to=%0d exp 1 40 1 0",
                     bus.o_frame_done, bus.o_frame_chk, bus.o_frame_err_cnt, n_to);
        end
        idle(3);
    endtask

    task automatic test_back_to_back;
        logic [1:0] lo;
        lo = 2'b11;
        bus.i_pix = 12'h000;
        bus.i_check_code = gcode(12'h000, 2'b00);
        bus.i_check_valid = 1'b1;
        bus.i_pix_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (!bus.o_wr_en || bus.o_wr_addr !== 15'(k % 8) ||
                bus.o_wr_data !== 12'(k % 8) || bus.o_frame_done !== (k == 8)) begin
                errors++;
                $display("FAIL t5_write%0d: got en=%b addr=%0d data=%h done=%b exp 1 %0d %h %b",
                         k, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data,
                         bus.o_frame_done, k % 8, k % 8, (k == 8));
            end
            if (k == 8) begin
                checks++;
                if (bus.o_frame_chk !== 8'h03 || bus.o_frame_err_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL t5_frame1: got chk=%h err=%0d exp 03 0",
                             bus.o_frame_chk, bus.o_frame_err_cnt);
                end
            end
            if (k < 15) begin
                lo = ((k + 1) == 2) ? 2'b11 : (((k + 1) == 14) ? 2'b01 : 2'b00);
                bus.i_pix = 12'((k + 1) % 8);
                bus.i_check_code = gcode(12'((k + 1) % 8), lo);
            end else begin
                bus.i_pix_valid = 1'b0;
                bus.i_check_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (bus.o_frame_done !== 1'b1 || bus.o_frame_chk !== 8'h01 ||
            bus.o_frame_err_cnt !== 8'd0 || bus.o_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL t5_frame2: got done=%b chk=%h err=%0d wr=%b exp 1 01 0 0",
                     bus.o_frame_done, bus.o_frame_chk, bus.o_frame_err_cnt, bus.o_wr_en);
        end
        idle(3);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) begin
            send(12'h200 + 12'(i), 8'h00, 1'b1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_frame_done,
             bus.o_frame_chk, bus.o_frame_err_cnt, bus.o_pix_err,
             bus.o_timeout, bus.o_busy} !== '0) begin
            errors++;
            $display("FAIL t6_async_clear: got en=%b addr=%0d data=%h perr=%b busy=%b exp all zero",
                     bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_pix_err, bus.o_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        idle(2);
        send(12'h055, gcode(12'h055, 2'b10), 1'b1);
        checks++;
        if (!bus.o_wr_en || bus.o_wr_addr !== 15'd0 || bus.o_wr_data !== 12'h055) begin
            errors++;
            $display("FAIL t6_restart: got en=%b addr=%0d data=%h exp 1 0 055",
                     bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
        end
        idle(20);
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL t6_stale_done: got %0d exp 0", n_done);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_mismatch();
        test_timeout();
        test_timeout_race();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
